// File: rtl/ava_work_loader_if.sv
// Host-byte input, transmitter handshake and committed work-packet outputs of the loader.
// Member prefixes are from the loader's point of view (i_ into it, o_ out of it).
interface ava_work_loader_if;
    logic [7:0]   i_rx_data;
    logic         i_rx_valid;
    logic         i_tx_busy;
    logic         o_start;
    logic [575:0] o_data;
    logic [7:0]   o_pll0;
    logic [7:0]   o_pll1;
    logic [7:0]   o_mode;
    logic         o_crc_err;
    logic         o_timeout_err;
    logic         o_drop;
    logic [7:0]   o_pkt_cnt;

    modport master (
        output i_rx_data, i_rx_valid, i_tx_busy,
        input  o_start, o_data, o_pll0, o_pll1, o_mode,
        input  o_crc_err, o_timeout_err, o_drop, o_pkt_cnt
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_busy,
        output o_start, o_data, o_pll0, o_pll1, o_mode,
        output o_crc_err, o_timeout_err, o_drop, o_pkt_cnt
    );
endinterface

// File: rtl/ava_work_loader.sv
// Parses sync-framed work packets from the host byte stream, verifies the additive checksum,
// commits fields to stable outputs and hands a one-cycle start to the ASIC transmitter.
module ava_work_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd32000
) (
    input  logic               i_clk,
    input  logic               i_global_reset_n,
    ava_work_loader_if.slave   bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECV    = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_WAIT_TX = 2'd3;

    localparam int          PAYLOAD_LEN = 75;
    localparam int          DATA_BYTES  = 72;
    localparam logic [6:0]  LAST_INDEX  = 7'd74;

    logic [1:0]   r_state;
    logic [7:0]   r_shadow [0:PAYLOAD_LEN-1];
    logic [6:0]   r_index;
    logic [7:0]   r_acc;
    logic [15:0]  r_idle_cnt;

    logic         r_start;
    logic         r_crc_err;
    logic         r_timeout_err;
    logic         r_drop;
    logic [575:0] r_data;
    logic [7:0]   r_pll0;
    logic [7:0]   r_pll1;
    logic [7:0]   r_mode;
    logic [7:0]   r_pkt_cnt;

    logic [575:0] w_shadow_data;

    // Shadow bytes 3..74 are the data field, byte k of data sits at shadow index k+3.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BYTES; gi++) begin : g_pack
            assign w_shadow_data[8*gi +: 8] = r_shadow[gi+3];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_global_reset_n) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_acc         <= '0;
            r_idle_cnt    <= '0;
            r_start       <= 1'b0;
            r_crc_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_drop        <= 1'b0;
            r_data        <= '0;
            r_pll0        <= '0;
            r_pll1        <= '0;
            r_mode        <= '0;
            r_pkt_cnt     <= '0;
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_start       <= 1'b0;
            r_crc_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_drop        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_rx_valid && bus.i_rx_data == SYNC_BYTE) begin
                        r_state    <= ST_RECV;
                        r_index    <= '0;
                        r_acc      <= '0;
                        r_idle_cnt <= '0;
                    end
                end
                ST_RECV, ST_CHECK: begin
                    // A byte landing on the timeout cycle still wins over the timeout.
                    if (bus.i_rx_valid) begin
                        r_idle_cnt <= '0;
                        if (r_state == ST_RECV) begin
                            r_shadow[r_index] <= bus.i_rx_data;
                            r_acc             <= r_acc + bus.i_rx_data;
                            r_index           <= r_index + 7'd1;
                            if (r_index == LAST_INDEX) begin
                                r_state <= ST_CHECK;
                            end
                        end else if (bus.i_rx_data == r_acc) begin
                            r_mode    <= r_shadow[0];
                            r_pll0    <= r_shadow[1];
                            r_pll1    <= r_shadow[2];
                            r_data    <= w_shadow_data;
                            r_pkt_cnt <= r_pkt_cnt + 8'd1;
                            r_state   <= ST_WAIT_TX;
                        end else begin
                            r_crc_err <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end else if (r_idle_cnt == TIMEOUT) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end
                end
                ST_WAIT_TX: begin
                    if (bus.i_rx_valid) begin
                        r_drop <= 1'b1;
                    end
                    if (!bus.i_tx_busy) begin
                        r_start <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_start       = r_start;
    assign bus.o_crc_err     = r_crc_err;
    assign bus.o_timeout_err = r_timeout_err;
    assign bus.o_drop        = r_drop;
    assign bus.o_data        = r_data;
    assign bus.o_pll0        = r_pll0;
    assign bus.o_pll1        = r_pll1;
    assign bus.o_mode        = r_mode;
    assign bus.o_pkt_cnt     = r_pkt_cnt;
endmodule
